// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the dmem arbiter: phase names, aux FSM encoding
// and a saturating counter helper.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_A0 = 2'd2,
        PH_A1 = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        AUX_IDLE = 2'd0,
        AUX_PEND = 2'd1,
        AUX_WAIT = 2'd2,
        AUX_ACK  = 2'd3
    } aux_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Processor, auxiliary and dmem-side signals of the arbiter, plus debug phase/state.
// Aux handshake: the requester raises aux_req with stable address/data/wren; the
// arbiter samples it only while IDLE and answers with a single-cycle aux_ack.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();

    logic [ADDR_W-1:0] proc_address;
    logic [DATA_W-1:0] proc_data;
    logic              proc_wren;
    logic [DATA_W-1:0] proc_q;

    logic              aux_req;
    logic              aux_wren;
    logic [ADDR_W-1:0] aux_address;
    logic [DATA_W-1:0] aux_data;
    logic              aux_ack;
    logic [DATA_W-1:0] aux_q;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    logic [1:0]        phase;
    aux_state_e        aux_state;

    modport master (
        output proc_address, proc_data, proc_wren,
        output aux_req, aux_wren, aux_address, aux_data,
        output mem_q,
        input  proc_q, aux_ack, aux_q,
        input  mem_address, mem_data, mem_wren,
        input  phase, aux_state
    );

    modport slave (
        input  proc_address, proc_data, proc_wren,
        input  aux_req, aux_wren, aux_address, aux_data,
        input  mem_q,
        output proc_q, aux_ack, aux_q,
        output mem_address, mem_data, mem_wren,
        output phase, aux_state
    );

endinterface

// File: rtl/dmem_phase_counter.sv
// Free-running 2-bit wrap counter with asynchronous active-low clear; tracks the
// fast-clock phase inside one divide-by-4 processor cycle.
module dmem_phase_counter (
    input  logic       clock,
    input  logic       reset,
    output logic [1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
        end else begin
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the processor (phases 0-1) and one aux requester
// (phases 2-3). Optional DMEM_ARB_STATS_EN adds saturating aux/processor-write counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = DMEM_ADDR_W,
    parameter int DATA_W        = DMEM_DATA_W,
    parameter int PROC_WR_PHASE = 1
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   aux_count,
    output logic [15:0]   proc_wr_count
`endif
);

    logic [1:0]        phase_cnt;
    phase_e            ph;
    aux_state_e        state_q, state_d;
    logic [ADDR_W-1:0] hold_address;
    logic [DATA_W-1:0] hold_data;
    logic              hold_wren;
    logic              latch_en;
    logic              proc_wr_gate;
    logic              ack;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] proc_q_r;
    logic [DATA_W-1:0] aux_q_r;

    dmem_phase_counter u_phase (
        .clock (clock),
        .reset (reset),
        .count (phase_cnt)
    );

    assign ph = phase_e'(phase_cnt);
    // PROC_WR_PHASE is 0 or 1, so the gate alone keeps processor writes inside its window.
    assign proc_wr_gate = bus.proc_wren && (phase_cnt == 2'(PROC_WR_PHASE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= AUX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        latch_en    = 1'b0;
        ack         = 1'b0;
        mem_address = bus.proc_address;
        mem_data    = bus.proc_data;
        mem_wren    = proc_wr_gate;
        case (state_q)
            AUX_IDLE: begin
                if (bus.aux_req) begin
                    latch_en = 1'b1;
                    state_d  = AUX_PEND;
                end
            end
            AUX_PEND: begin
                if (ph == PH_A0) begin
                    mem_address = hold_address;
                    mem_data    = hold_data;
                    mem_wren    = hold_wren;
                    state_d     = AUX_WAIT;
                end
            end
            AUX_WAIT: state_d = AUX_ACK;
            AUX_ACK: begin
                ack     = 1'b1;
                state_d = AUX_IDLE;
            end
            default: state_d = AUX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_address <= '0;
            hold_data    <= '0;
            hold_wren    <= 1'b0;
            proc_q_r     <= '0;
            aux_q_r      <= '0;
        end else begin
            if (latch_en) begin
                hold_address <= bus.aux_address;
                hold_data    <= bus.aux_data;
                hold_wren    <= bus.aux_wren;
            end
            // mem_q during phase 1 is the read launched by the phase-0 address.
            if (ph == PH_P1) begin
                proc_q_r <= bus.mem_q;
            end
            if (state_q == AUX_WAIT && !hold_wren) begin
                aux_q_r <= bus.mem_q;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aux_count     <= 16'd0;
            proc_wr_count <= 16'd0;
        end else begin
            if (ack) begin
                aux_count <= sat_inc(aux_count);
            end
            if (proc_wr_gate) begin
                proc_wr_count <= sat_inc(proc_wr_count);
            end
        end
    end
`endif

    assign bus.mem_address = mem_address;
    assign bus.mem_data    = mem_data;
    assign bus.mem_wren    = mem_wren;
    assign bus.proc_q      = proc_q_r;
    assign bus.aux_q       = aux_q_r;
    assign bus.aux_ack     = ack;
    assign bus.phase       = phase_cnt;
    assign bus.aux_state   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural dmem; exercises the
// DMEM_ARB_STATS_EN counters when that macro is defined.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int WR_PH = 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] aux_count;
    logic [15:0] proc_wr_count;
`endif

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PROC_WR_PHASE(WR_PH)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .aux_count     (aux_count),
        .proc_wr_count (proc_wr_count)
`endif
    );

    // Behavioural single-port dmem: registered read returns old data on a same-cycle write.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
        bus.mem_q <= mem[bus.mem_address];
    end

    logic [2+AW+DW-1:0] wr_exp_q[$];
    logic [DW-1:0]      aux_exp_q[$];
    logic [DW-1:0]      proc_exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic proc_chk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    task automatic to_phase(input logic [1:0] p);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (bus.phase != p && n < 8);
        if (bus.phase != p) fail_event("phase_wait_timeout", 64'(bus.phase));
    endtask

    task automatic proc_set(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic wren, input logic chk, input logic [DW-1:0] exp);
        bus.proc_address = addr;
        bus.proc_data    = data;
        bus.proc_wren    = wren;
        proc_chk         = chk;
        if (wren) wr_exp_q.push_back({2'(WR_PH), addr, data});
        if (chk) proc_exp_q.push_back(exp);
    endtask

    task automatic aux_set(input logic req, input logic wren, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
        bus.aux_req     = req;
        bus.aux_wren    = wren;
        bus.aux_address = addr;
        bus.aux_data    = data;
    endtask

    // Monitor: pops the expected queues whenever the DUT shows a write, an ack or a proc read.
    initial begin
        logic               chk_l;
        logic [2+AW+DW-1:0] w;
        logic [DW-1:0]      e;
        chk_l = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (bus.mem_wren) begin
                    if (wr_exp_q.size() == 0) begin
                        fail_event("unexpected_write", 64'({bus.phase, bus.mem_address}));
                    end else begin
                        w = wr_exp_q.pop_front();
                        check("mem_write", 64'({bus.phase, bus.mem_address, bus.mem_data}), 64'(w));
                    end
                end
                if (bus.aux_ack) begin
                    check("aux_ack_phase", 64'(bus.phase), 64'(0));
                    if (aux_exp_q.size() == 0) begin
                        fail_event("unexpected_aux_ack", 64'(bus.aux_q));
                    end else begin
                        e = aux_exp_q.pop_front();
                        check("aux_q", 64'(bus.aux_q), 64'(e));
                    end
                end
                if (bus.phase == 2'd0) chk_l = proc_chk;
                if (bus.phase == 2'd2 && chk_l) begin
                    chk_l = 1'b0;
                    if (proc_exp_q.size() == 0) begin
                        fail_event("proc_q_no_expectation", 64'(bus.proc_q));
                    end else begin
                        e = proc_exp_q.pop_front();
                        check("proc_q", 64'(bus.proc_q), 64'(e));
                    end
                end
            end else begin
                chk_l = 1'b0;
                if (bus.aux_ack) fail_event("aux_ack_in_reset", 64'(bus.aux_ack));
            end
        end
    end

    initial begin
        proc_set('0, '0, 1'b0, 1'b0, '0);
        aux_set(1'b0, 1'b0, '0, '0);

        // Reset state and phase sequence after release
        repeat (3) @(posedge clock);
        #1;
        check("rst_phase", 64'(bus.phase), 64'(0));
        check("rst_proc_q", 64'(bus.proc_q), 64'(0));
        check("rst_aux_q", 64'(bus.aux_q), 64'(0));
        check("rst_aux_ack", 64'(bus.aux_ack), 64'(0));
        check("rst_state", 64'(bus.aux_state), 64'(AUX_IDLE));
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("phase_seq", 64'(bus.phase), 64'(i % 4));
            check("idle_mem_wren", 64'(bus.mem_wren), 64'(0));
            @(posedge clock);
            #1;
        end

        // Processor write held for one processor cycle, then read back
        to_phase(2'd0);
        proc_set(12'h010, 32'hDEADBEEF, 1'b1, 1'b0, '0);
        to_phase(2'd0);
        proc_set(12'h010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

        // Aux read raised in phase 0
        to_phase(2'd0);
        proc_set(12'h000, 32'h0, 1'b0, 1'b0, '0);
        aux_set(1'b1, 1'b0, 12'h010, 32'h0);
        aux_exp_q.push_back(32'hDEADBEEF);
        @(posedge clock);
        #1;
        aux_set(1'b0, 1'b0, 12'h000, 32'h0);
        @(posedge clock);
        @(negedge clock);
        check("aux_rd_phase", 64'(bus.phase), 64'(2));
        check("aux_rd_mem_address", 64'(bus.mem_address), 64'(12'h010));
        to_phase(2'd0);
        proc_set(12'h000, 32'h0, 1'b0, 1'b0, '0);

        // Concurrent processor write (phase 1) and aux write (phase 2)
        to_phase(2'd0);
        proc_set(12'h021, 32'hAAAA5555, 1'b1, 1'b0, '0);
        aux_set(1'b1, 1'b1, 12'h020, 32'h12345678);
        wr_exp_q.push_back({2'd2, 12'h020, 32'h12345678});
        aux_exp_q.push_back(32'hDEADBEEF);
        @(posedge clock);
        #1;
        aux_set(1'b0, 1'b0, 12'h000, 32'h0);
        to_phase(2'd0);
        proc_set(12'h020, 32'h0, 1'b0, 1'b1, 32'h12345678);
        to_phase(2'd0);
        proc_set(12'h021, 32'h0, 1'b0, 1'b1, 32'hAAAA5555);

        // aux_req held high for 12 cycles: three back-to-back reads
        to_phase(2'd0);
        proc_set(12'h000, 32'h0, 1'b0, 1'b0, '0);
        aux_set(1'b1, 1'b0, 12'h020, 32'h0);
        repeat (3) aux_exp_q.push_back(32'h12345678);
        repeat (12) begin
            @(posedge clock);
            #1;
        end
        aux_set(1'b0, 1'b0, 12'h000, 32'h0);

        // Reset asserted while the aux access is in WAIT
        to_phase(2'd0);
`ifdef DMEM_ARB_STATS_EN
        check("aux_count", 64'(aux_count), 64'(5));
        check("proc_wr_count", 64'(proc_wr_count), 64'(2));
`endif
        aux_set(1'b1, 1'b0, 12'h010, 32'h0);
        @(posedge clock);
        #1;
        aux_set(1'b0, 1'b0, 12'h000, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check("pre_rst_state", 64'(bus.aux_state), 64'(AUX_WAIT));
        reset = 1'b0;
        #1;
        check("mid_rst_state", 64'(bus.aux_state), 64'(AUX_IDLE));
        check("mid_rst_phase", 64'(bus.phase), 64'(0));
        check("mid_rst_aux_q", 64'(bus.aux_q), 64'(0));
        check("mid_rst_proc_q", 64'(bus.proc_q), 64'(0));
        check("mid_rst_aux_ack", 64'(bus.aux_ack), 64'(0));
`ifdef DMEM_ARB_STATS_EN
        check("rst_aux_count", 64'(aux_count), 64'(0));
        check("rst_proc_wr_count", 64'(proc_wr_count), 64'(0));
`endif
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (8) begin
            @(posedge clock);
            #1;
        end
        check("post_rst_aux_q", 64'(bus.aux_q), 64'(0));
        check("post_rst_state", 64'(bus.aux_state), 64'(AUX_IDLE));

        // Every expected event must have been observed
        repeat (8) @(posedge clock);
        #1;
        check("wr_queue_drained", 64'(wr_exp_q.size()), 64'(0));
        check("aux_queue_drained", 64'(aux_exp_q.size()), 64'(0));
        check("proc_queue_drained", 64'(proc_exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
